game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter NUM_LEVELS, default 3, is the number of selectable difficulty levels (legal range 1..4).
REQ-002 Parameter CLK_HZ, default 65_000_000, is the clk cycles per game second.
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 level_req  input  NUM_LEVELS  one-hot-intended level select pulses/levels (button inputs).
REQ-006 restart  input  1  return-to-idle request.
REQ-007 explode  input  1  single-cycle pulse, mine clicked.
REQ-008 flag_set / flag_clr  input  1 each  single-cycle pulses, flag placed/removed.
REQ-009 defuse  input  1  single-cycle pulse, mine correctly flagged.
REQ-010 state  output  game_state_t  current FSM state.
REQ-011 level_idx  output  2  latched level index.
REQ-012 game_active / game_over / game_won  output  1 each  registered status flags.
REQ-013 sec_bcd  output  8  seconds remaining, two BCD digits.
REQ-014 mines_bcd  output  8  mines remaining (mines minus flags), two BCD digits.
REQ-015 tick_1hz  output  1  one-cycle pulse per game second while in PLAY.

Function
REQ-016 FSM states IDLE, SETUP, PLAY, WON, LOST; all outputs registered.
REQ-017 IDLE: when any level_req bit is set, latch the lowest set index into level_idx, go to SETUP; level_req is ignored in all other states.
REQ-018 SETUP (exactly one cycle): load sec_bcd = LEVEL_SECONDS[level_idx], mines_bcd = LEVEL_MINES[level_idx], clear defuse count and prescaler, go to PLAY.
REQ-019 PLAY: game_active = 1; prescaler counts 0..CLK_HZ-1, at terminal count pulses tick_1hz and BCD-decrements sec_bcd (e.g. 0x10 -> 0x09).
REQ-020 PLAY exit priority in one cycle: explode -> LOST; else tick with sec_bcd = 0x01 -> LOST with sec_bcd = 0x00; else defuse count reaching latched mine total -> WON; else stay.
REQ-021 flag_set decrements mines_bcd, saturating at 0x00; flag_clr increments, saturating at latched total; both asserted in one cycle -> no change; flags ignored outside PLAY.
REQ-022 defuse increments an internal binary count (6 bits), saturating at latched total; WON is entered on the cycle after the count equals total.
REQ-023 WON: game_won = 1; LOST: game_over = 1; sec_bcd and mines_bcd freeze; tick_1hz = 0.
REQ-024 restart in PLAY, WON or LOST -> IDLE next cycle; restart in IDLE/SETUP is ignored; restart has priority over all PLAY transitions.
REQ-025 A level with LEVEL_SECONDS = 0x00 enters LOST on the first cycle of PLAY.

Reset
REQ-026 rst low on a clock edge: state = IDLE, level_idx = 0, all flags 0, sec_bcd = 0x00, mines_bcd = 0x00, prescaler and defuse count 0, tick_1hz = 0; applies mid-game with no residual state.

Structure
REQ-027 Package game_ctrl_pkg holds game_state_t and constant arrays LEVEL_SECONDS and LEVEL_MINES (BCD, 4 entries: 0x99/0x10, 0x99/0x20, 0x99/0x40, 0x60/0x50).
REQ-028 Sub-module game_tick_gen (parameter CLK_HZ; ports clk, rst, clear, enable, tick) implements the prescaler.
REQ-029 BCD increment/decrement are functions in game_ctrl_pkg; no binary-to-BCD converter is used.

Verification (CLK_HZ = 4)
REQ-030 level_req = 3'b110 in IDLE -> level_idx = 1, SETUP one cycle, PLAY with sec_bcd = 0x99, mines_bcd = 0x20.
REQ-031 Level 0 in PLAY, 990 cycles -> sec_bcd steps through 0x10 -> 0x09 -> ... -> 0x00, LOST with game_over = 1 at the 0x01 -> 0x00 tick.
REQ-032 Level 0, flag_set 12 times -> mines_bcd = 0x00 (saturated); then flag_set + flag_clr in one cycle -> 0x00; flag_clr -> 0x01.
REQ-033 Level 0, 10 defuse pulses -> WON next cycle, game_won = 1, sec_bcd frozen; explode afterwards -> state stays WON.
REQ-034 In PLAY, explode and restart in the same cycle -> IDLE, game_over = 0.
REQ-035 rst low mid-PLAY -> all outputs at reset values next edge; new level_req restarts cleanly with full timer.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared types, per-level constants and BCD helpers for the game controller.
package game_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PLAY  = 3'd2,
        WON   = 3'd3,
        LOST  = 3'd4
    } game_state_t;

    // Per-level timer start value and mine count, both in two-digit BCD.
    localparam logic [7:0] LEVEL_SECONDS [4] = '{8'h99, 8'h99, 8'h99, 8'h60};
    localparam logic [7:0] LEVEL_MINES   [4] = '{8'h10, 8'h20, 8'h40, 8'h50};

    // Two-digit BCD increment; callers keep the value below 0x99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] b);
        if (b[3:0] == 4'd9) return {b[7:4] + 4'd1, 4'd0};
        else                return {b[7:4], b[3:0] + 4'd1};
    endfunction

    // Two-digit BCD decrement; callers keep the value above 0x00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] b);
        if (b[3:0] == 4'd0) return {b[7:4] - 4'd1, 4'd9};
        else                return {b[7:4], b[3:0] - 4'd1};
    endfunction

    // Mine totals are at most 50, so the 6-bit result never truncates a table entry.
    function automatic logic [5:0] bcd_to_bin(input logic [7:0] b);
        logic [6:0] t;
        t = {3'b000, b[7:4]} * 7'd10 + {3'b000, b[3:0]};
        return t[5:0];
    endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Game-second prescaler: counts enabled cycles 0..CLK_HZ-1, flags the terminal count.
module game_tick_gen #(
    parameter int CLK_HZ = 65_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt;

    // Prescaler counter; holds while disabled, wraps at the terminal count.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == TERM) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = enable && (cnt == TERM);

endmodule

// File: rtl/game_ctrl.sv
// Minesweeper-style game controller: level select, countdown timer, mine/flag bookkeeping.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int NUM_LEVELS = 3,
    parameter int CLK_HZ     = 65_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_LEVELS-1:0] level_req,
    input  logic                  restart,
    input  logic                  explode,
    input  logic                  flag_set,
    input  logic                  flag_clr,
    input  logic                  defuse,
    output game_state_t           state,
    output logic [1:0]            level_idx,
    output logic                  game_active,
    output logic                  game_over,
    output logic                  game_won,
    output logic [7:0]            sec_bcd,
    output logic [7:0]            mines_bcd,
    output logic                  tick_1hz
);

    game_state_t state_next;
    logic        tick;
    logic        req_any;
    logic [1:0]  req_idx;
    logic [5:0]  defuse_cnt;
    logic [5:0]  mine_total;
    logic [7:0]  mine_total_bcd;

    assign mine_total_bcd = LEVEL_MINES[level_idx];
    assign mine_total     = bcd_to_bin(mine_total_bcd);

    game_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == SETUP),
        .enable (state == PLAY),
        .tick   (tick)
    );

    // Pick the lowest-numbered requested level (scan downwards so the lowest wins).
    always_comb begin
        req_any = |level_req;
        req_idx = 2'd0;
        for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
            if (level_req[i]) req_idx = 2'(i);
        end
    end

    // Next-state logic; restart outranks every PLAY exit, explode outranks timeout and win.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (req_any) state_next = SETUP;
            SETUP: state_next = PLAY;
            PLAY: begin
                if (restart)                                         state_next = IDLE;
                else if (explode)                                    state_next = LOST;
                else if ((sec_bcd == 8'h00) ||
                         (tick && sec_bcd == 8'h01))                 state_next = LOST;
                else if (defuse_cnt == mine_total)                   state_next = WON;
            end
            WON:   if (restart) state_next = IDLE;
            LOST:  if (restart) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Registered status flags, level latch, timer, mine counter and defuse count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            level_idx   <= 2'd0;
            game_active <= 1'b0;
            game_over   <= 1'b0;
            game_won    <= 1'b0;
            sec_bcd     <= 8'h00;
            mines_bcd   <= 8'h00;
            defuse_cnt  <= 6'd0;
            tick_1hz    <= 1'b0;
        end else begin
            game_active <= (state_next == PLAY);
            game_over   <= (state_next == LOST);
            game_won    <= (state_next == WON);
            // The final tick that ends the game is not reported outside PLAY.
            tick_1hz    <= tick && (state_next == PLAY);
            case (state)
                IDLE: begin
                    if (req_any) level_idx <= req_idx;
                end
                SETUP: begin
                    sec_bcd    <= LEVEL_SECONDS[level_idx];
                    mines_bcd  <= mine_total_bcd;
                    defuse_cnt <= 6'd0;
                end
                PLAY: begin
                    if (tick && sec_bcd != 8'h00) sec_bcd <= bcd_dec(sec_bcd);
                    if (flag_set && !flag_clr && mines_bcd != 8'h00)
                        mines_bcd <= bcd_dec(mines_bcd);
                    else if (flag_clr && !flag_set && mines_bcd != mine_total_bcd)
                        mines_bcd <= bcd_inc(mines_bcd);
                    if (defuse && defuse_cnt < mine_total) defuse_cnt <= defuse_cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus randomized play against an integer model.
module tb_game_ctrl;
    import game_ctrl_pkg::*;

    localparam int CLK_HZ = 4;
    localparam int NUM_LEVELS = 3;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  level_req = '0;
    logic        restart = 1'b0, explode = 1'b0, flag_set = 1'b0, flag_clr = 1'b0, defuse = 1'b0;
    game_state_t state;
    logic [1:0]  level_idx;
    logic        game_active, game_over, game_won, tick_1hz;
    logic [7:0]  sec_bcd, mines_bcd;

    always #5 clk = ~clk;

    game_ctrl #(.NUM_LEVELS(NUM_LEVELS), .CLK_HZ(CLK_HZ)) dut (
        .clk(clk), .rst(rst), .level_req(level_req), .restart(restart), .explode(explode),
        .flag_set(flag_set), .flag_clr(flag_clr), .defuse(defuse), .state(state),
        .level_idx(level_idx), .game_active(game_active), .game_over(game_over),
        .game_won(game_won), .sec_bcd(sec_bcd), .mines_bcd(mines_bcd), .tick_1hz(tick_1hz)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- behavioural model (integer seconds / mines) ----------------
    localparam int P_IDLE = 0, P_SETUP = 1, P_PLAY = 2, P_WON = 3, P_LOST = 4;
    int lvl_secs  [4] = '{99, 99, 99, 60};
    int lvl_mines [4] = '{10, 20, 40, 50};
    int m_phase = P_IDLE, m_lvl = 0, m_secs = 0, m_mines = 0, m_def = 0, m_pc = 0;
    int m_tick = 0;

    function automatic logic [7:0] to_bcd(input int n);
        return 8'((n / 10) * 16 + (n % 10));
    endfunction

    function automatic game_state_t phase_state(input int p);
        case (p)
            P_SETUP: return SETUP;
            P_PLAY:  return PLAY;
            P_WON:   return WON;
            P_LOST:  return LOST;
            default: return IDLE;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic [2:0] lr, input logic rs, input logic ex,
                              input logic fs, input logic fc, input logic df);
        int nph;
        int tk;
        int total;
        if (!r) begin
            m_phase = P_IDLE; m_lvl = 0; m_secs = 0; m_mines = 0; m_def = 0; m_pc = 0; m_tick = 0;
            return;
        end
        nph = m_phase;
        m_tick = 0;
        total = lvl_mines[m_lvl];
        case (m_phase)
            P_IDLE: begin
                if (lr != 3'b000) begin
                    for (int i = 2; i >= 0; i--) if (lr[i]) m_lvl = i;
                    nph = P_SETUP;
                end
            end
            P_SETUP: begin
                m_secs = lvl_secs[m_lvl];
                m_mines = lvl_mines[m_lvl];
                m_def = 0;
                m_pc = 0;
                nph = P_PLAY;
            end
            P_PLAY: begin
                tk = (m_pc == CLK_HZ - 1) ? 1 : 0;
                m_pc = (m_pc + 1) % CLK_HZ;
                if (rs)                                        nph = P_IDLE;
                else if (ex)                                   nph = P_LOST;
                else if (m_secs == 0 || (tk == 1 && m_secs == 1)) nph = P_LOST;
                else if (m_def == total)                       nph = P_WON;
                if (tk == 1 && m_secs > 0) m_secs--;
                if (fs && !fc && m_mines > 0)          m_mines--;
                else if (fc && !fs && m_mines < total) m_mines++;
                if (df && m_def < total) m_def++;
                m_tick = (tk == 1 && nph == P_PLAY) ? 1 : 0;
            end
            default: if (rs) nph = P_IDLE;
        endcase
        m_phase = nph;
    endtask

    // ---------------- driver ----------------
    task automatic check_outputs();
        check_eq("state",       32'(state),       32'(phase_state(m_phase)));
        check_eq("level_idx",   32'(level_idx),   32'(m_lvl));
        check_eq("game_active", 32'(game_active), 32'(m_phase == P_PLAY));
        check_eq("game_over",   32'(game_over),   32'(m_phase == P_LOST));
        check_eq("game_won",    32'(game_won),    32'(m_phase == P_WON));
        check_eq("sec_bcd",     32'(sec_bcd),     32'(to_bcd(m_secs)));
        check_eq("mines_bcd",   32'(mines_bcd),   32'(to_bcd(m_mines)));
        check_eq("tick_1hz",    32'(tick_1hz),    32'(m_tick));
    endtask

    task automatic step(input logic r, input logic [2:0] lr, input logic rs, input logic ex,
                        input logic fs, input logic fc, input logic df);
        rst = r; level_req = lr; restart = rs; explode = ex;
        flag_set = fs; flag_clr = fc; defuse = df;
        @(posedge clk);
        model_step(r, lr, rs, ex, fs, fc, df);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_level(input logic [2:0] lr);
        step(1'b1, lr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int budget;
        logic [2:0] lr;

        // Reset state
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_state", 32'(state), 32'(IDLE));
        check_eq("rst_sec", 32'(sec_bcd), 32'h00);
        idle(2);

        // Lowest requested level wins; SETUP lasts one cycle
        step(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("setup_state", 32'(state), 32'(SETUP));
        idle(1);
        check_eq("play_state", 32'(state), 32'(PLAY));
        check_eq("lvl1_idx", 32'(level_idx), 32'd1);
        check_eq("lvl1_sec", 32'(sec_bcd), 32'h99);
        check_eq("lvl1_mines", 32'(mines_bcd), 32'h20);
        level_req = 3'b001;
        idle(6);
        step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("restart_idle", 32'(state), 32'(IDLE));

        // Level 0 runs the timer all the way down
        start_level(3'b001);
        budget = 990;
        while (m_phase == P_PLAY && budget > 0) begin
            idle(1);
            budget--;
        end
        check_eq("timeout_reached", 32'(budget > 0), 32'd1);
        check_eq("timeout_state", 32'(state), 32'(LOST));
        check_eq("timeout_over", 32'(game_over), 32'd1);
        check_eq("timeout_sec", 32'(sec_bcd), 32'h00);
        idle(3);
        step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Flag saturation at zero, simultaneous set+clr, then clear
        start_level(3'b001);
        for (int i = 0; i < 12; i++) step(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("flags_sat", 32'(mines_bcd), 32'h00);
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("flags_both", 32'(mines_bcd), 32'h00);
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("flags_clr", 32'(mines_bcd), 32'h01);

        // Ten defuses win the game the cycle after; explode is then ignored
        for (int i = 0; i < 10; i++) step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("win_not_yet", 32'(state), 32'(PLAY));
        idle(1);
        check_eq("win_state", 32'(state), 32'(WON));
        check_eq("win_flag", 32'(game_won), 32'd1);
        idle(6);
        check_eq("win_sec_frozen", 32'(sec_bcd), 32'(to_bcd(m_secs)));
        step(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("win_after_explode", 32'(state), 32'(WON));
        step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Restart outranks explode
        start_level(3'b100);
        idle(3);
        step(1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("rs_ex_state", 32'(state), 32'(IDLE));
        check_eq("rs_ex_over", 32'(game_over), 32'd0);

        // Reset mid-game, then a clean new game
        start_level(3'b010);
        idle(9);
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("midrst_state", 32'(state), 32'(IDLE));
        check_eq("midrst_idx", 32'(level_idx), 32'd0);
        check_eq("midrst_mines", 32'(mines_bcd), 32'h00);
        check_eq("midrst_active", 32'(game_active), 32'd0);
        start_level(3'b001);
        check_eq("newgame_sec", 32'(sec_bcd), 32'h99);
        check_eq("newgame_mines", 32'(mines_bcd), 32'h10);

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            lr = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            step(($urandom_range(0, 999) != 0),
                 lr,
                 ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 249) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 6) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
